// File: rtl/regfile_mp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp_pkg
//  Description : Shared constants for the multi-port register file.
//                Supplies the word width, register count and zero-register
//                defaults used as parameter defaults by regfile_mp.
//  Revision    : 1.0 - initial multi-port release
// ============================================================================

`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef REG_NUM
`define REG_NUM 32
`endif
`ifndef REG_NUM_LOG
`define REG_NUM_LOG 5
`endif
`ifndef RF_ZERO_REG
`define RF_ZERO_REG 1
`endif

package regfile_mp_pkg;
  localparam int RF_WIDTH    = `WORD_WIDTH;
  localparam int RF_DEPTH    = `REG_NUM;
  localparam int RF_ZERO_REG = `RF_ZERO_REG;
endpackage

`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wr_arbiter
//  Description : Resolves the NWRITE write ports against one address.
//                Ports are scanned in ascending order so the highest-index
//                enabled port that matches supplies the data.
//  Ports       : i_addr    - address being resolved
//                i_wr_en   - per-port write enables
//                i_wr_addr - packed write addresses
//                i_wr_data - packed write data
//                o_hit     - some enabled port targets i_addr
//                o_data    - winning write data (0 when no hit)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_arbiter #(
  parameter int WIDTH  = 32,
  parameter int AW     = 5,
  parameter int NWRITE = 2
) (
  input  logic [AW-1:0]           i_addr,
  input  logic [NWRITE-1:0]       i_wr_en,
  input  logic [NWRITE*AW-1:0]    i_wr_addr,
  input  logic [NWRITE*WIDTH-1:0] i_wr_data,
  output logic                    o_hit,
  output logic [WIDTH-1:0]        o_data
);

  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    // Later matches overwrite earlier ones: highest index wins.
    for (int k = 0; k < NWRITE; k++) begin
      if (i_wr_en[k] && (i_wr_addr[k*AW +: AW] == i_addr)) begin
        o_hit  = 1'b1;
        o_data = i_wr_data[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Parametrised multi-port register file with busy scoreboard
//                and same-cycle write-to-read bypass.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                wr_en/addr/data - NWRITE packed write ports
//                rsv_en/addr   - mark a destination register busy
//                rd_addr       - NREAD packed read addresses
//                rd_data       - packed read data (combinational)
//                rd_busy       - per read port, value not yet produced
//                busy_cnt      - registered popcount of busy registers
//  Revision    : 1.0 - initial multi-port release
// ============================================================================
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int  WIDTH    = RF_WIDTH,
  parameter int  DEPTH    = RF_DEPTH,
  parameter int  NREAD    = 2,
  parameter int  NWRITE   = 2,
  parameter int  ZERO_REG = RF_ZERO_REG,
  parameter int  BYPASS   = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NWRITE-1:0]       wr_en,
  input  logic [NWRITE*AW-1:0]    wr_addr,
  input  logic [NWRITE*WIDTH-1:0] wr_data,
  input  logic                    rsv_en,
  input  logic [AW-1:0]           rsv_addr,
  input  logic [NREAD*AW-1:0]     rd_addr,
  output logic [NREAD*WIDTH-1:0]  rd_data,
  output logic [NREAD-1:0]        rd_busy,
  output logic [AW:0]             busy_cnt
);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [AW:0]       r_busy_cnt;

  logic [NWRITE-1:0] w_wr_en;
  logic              w_rsv_en;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic [AW:0]       w_busy_cnt;

  // Dropping address-0 traffic at the source keeps register 0 at its reset
  // value and never busy, and keeps it out of every bypass path.
  always_comb begin
    for (int k = 0; k < NWRITE; k++) begin
      w_wr_en[k] = wr_en[k] &&
                   !((ZERO_REG != 0) && (wr_addr[k*AW +: AW] == '0));
    end
  end
  assign w_rsv_en = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

  // Storage and busy update, one arbiter per register.
  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    logic             w_hit;
    logic [WIDTH-1:0] w_data;

    regfile_wr_arbiter #(
      .WIDTH  (WIDTH),
      .AW     (AW),
      .NWRITE (NWRITE)
    ) u_arb (
      .i_addr    (AW'(i)),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .o_hit     (w_hit),
      .o_data    (w_data)
    );

    // A reservation beats a retiring write: the new producer is still pending.
    assign w_busy_nxt[i] = (w_rsv_en && (rsv_addr == AW'(i))) ? 1'b1 :
                           w_hit                             ? 1'b0 :
                                                               r_busy[i];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_mem[i] <= '0;
      end else if (w_hit) begin
        r_mem[i] <= w_data;
      end
    end
  end

  // Counting the next-state vector keeps busy_cnt exact under multi-port clears.
  always_comb begin
    w_busy_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_busy_cnt = w_busy_cnt + (AW+1)'(w_busy_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_busy_cnt;
    end
  end

  assign busy_cnt = r_busy_cnt;

  // Read ports.
  for (genvar j = 0; j < NREAD; j++) begin : g_rd
    logic [AW-1:0]    w_raddr;
    logic             w_hit;
    logic [WIDTH-1:0] w_hdata;
    logic [WIDTH-1:0] w_rdata;
    logic             w_rbusy;

    assign w_raddr = rd_addr[j*AW +: AW];

    if (BYPASS != 0) begin : g_byp
      regfile_wr_arbiter #(
        .WIDTH  (WIDTH),
        .AW     (AW),
        .NWRITE (NWRITE)
      ) u_arb (
        .i_addr    (w_raddr),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .o_hit     (w_hit),
        .o_data    (w_hdata)
      );
    end else begin : g_nobyp
      assign w_hit   = 1'b0;
      assign w_hdata = '0;
    end

    always_comb begin
      w_rdata = r_mem[w_raddr];
      w_rbusy = r_busy[w_raddr];
      if (rst || ((ZERO_REG != 0) && (w_raddr == '0))) begin
        w_rdata = '0;
        w_rbusy = 1'b0;
      end else if (w_hit) begin
        w_rdata = w_hdata;
        w_rbusy = 1'b0;
      end
    end

    assign rd_data[j*WIDTH +: WIDTH] = w_rdata;
    assign rd_busy[j]                = w_rbusy;
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Self-checking bench for regfile_mp. Drives a bypassing and a
//                non-bypassing instance with the same stimulus; expected
//                values are queued with each stimulus step and compared at
//                the sample points.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  localparam int c_w  = 32;
  localparam int c_aw = 5;

  localparam logic [3:0] c_rd0    = 4'd0;
  localparam logic [3:0] c_rd1    = 4'd1;
  localparam logic [3:0] c_bsy0   = 4'd2;
  localparam logic [3:0] c_bsy1   = 4'd3;
  localparam logic [3:0] c_cnt    = 4'd4;
  localparam logic [3:0] c_nb_rd0 = 4'd5;
  localparam logic [3:0] c_nb_bs0 = 4'd6;
  localparam logic [3:0] c_nb_cnt = 4'd7;

  typedef struct packed {
    logic [3:0]  kind;
    logic [31:0] val;
  } sb_t;

  logic                clk;
  logic                rst;
  logic [1:0]          wr_en;
  logic [2*c_aw-1:0]   wr_addr;
  logic [2*c_w-1:0]    wr_data;
  logic                rsv_en;
  logic [c_aw-1:0]     rsv_addr;
  logic [2*c_aw-1:0]   rd_addr;
  logic [2*c_w-1:0]    rd_data;
  logic [1:0]          rd_busy;
  logic [c_aw:0]       busy_cnt;
  logic [2*c_w-1:0]    nb_rd_data;
  logic [1:0]          nb_rd_busy;
  logic [c_aw:0]       nb_busy_cnt;

  sb_t q_now[$];
  sb_t q_post[$];
  int  n_chk = 0;
  int  n_err = 0;

  regfile_mp #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .busy_cnt(busy_cnt)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
    .busy_cnt(nb_busy_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic string kname(input logic [3:0] k);
    case (k)
      c_rd0:    return "rd_data0";
      c_rd1:    return "rd_data1";
      c_bsy0:   return "rd_busy0";
      c_bsy1:   return "rd_busy1";
      c_cnt:    return "busy_cnt";
      c_nb_rd0: return "nobyp_rd_data0";
      c_nb_bs0: return "nobyp_rd_busy0";
      default:  return "nobyp_busy_cnt";
    endcase
  endfunction

  function automatic logic [31:0] obs(input logic [3:0] k);
    case (k)
      c_rd0:    return rd_data[31:0];
      c_rd1:    return rd_data[63:32];
      c_bsy0:   return {31'b0, rd_busy[0]};
      c_bsy1:   return {31'b0, rd_busy[1]};
      c_cnt:    return {26'b0, busy_cnt};
      c_nb_rd0: return nb_rd_data[31:0];
      c_nb_bs0: return {31'b0, nb_rd_busy[0]};
      default:  return {26'b0, nb_busy_cnt};
    endcase
  endfunction

  task automatic exp_now(input logic [3:0] k, input logic [31:0] v);
    q_now.push_back(sb_t'{kind: k, val: v});
  endtask

  task automatic exp_post(input logic [3:0] k, input logic [31:0] v);
    q_post.push_back(sb_t'{kind: k, val: v});
  endtask

  task automatic drain_now();
    sb_t e;
    while (q_now.size() > 0) begin
      e = q_now.pop_front();
      chk(kname(e.kind), obs(e.kind), e.val);
    end
  endtask

  task automatic drain_post();
    sb_t e;
    while (q_post.size() > 0) begin
      e = q_post.pop_front();
      chk(kname(e.kind), obs(e.kind), e.val);
    end
  endtask

  task automatic idle();
    wr_en  = 2'b00;
    rsv_en = 1'b0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    wr_en[p]              = 1'b1;
    wr_addr[p*c_aw +: c_aw] = a;
    wr_data[p*c_w +: c_w]   = d;
  endtask

  task automatic rsv(input logic [4:0] a);
    rsv_en   = 1'b1;
    rsv_addr = a;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  // Called at a falling edge with inputs set: combinational checks settle,
  // then the rising edge, then registered checks, then the next falling edge.
  task automatic step();
    #1;
    drain_now();
    @(posedge clk);
    #1;
    drain_post();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; rd_addr = '0;
    @(negedge clk);

    // Writes during reset are discarded; reads are forced to 0.
    wr(0, 5'd5, 32'hDEADBEEF); rd(5'd5, 5'd5);
    exp_now(c_rd0, 32'h0); exp_now(c_bsy0, 32'h0);
    exp_post(c_cnt, 32'h0);
    step();
    rst = 1'b0; idle(); rd(5'd5, 5'd5);
    exp_now(c_rd0, 32'h0); exp_now(c_rd1, 32'h0); exp_now(c_bsy0, 32'h0);
    exp_now(c_nb_rd0, 32'h0); exp_now(c_cnt, 32'h0);
    step();

    // Basic write then read on both ports.
    wr(0, 5'd3, 32'h12345678); rd(5'd1, 5'd1);
    step();
    idle(); rd(5'd3, 5'd3);
    exp_now(c_rd0, 32'h12345678); exp_now(c_rd1, 32'h12345678);
    exp_now(c_bsy0, 32'h0); exp_now(c_bsy1, 32'h0);
    exp_now(c_nb_rd0, 32'h12345678);
    step();

    // Same-cycle bypass versus stored-only read.
    wr(1, 5'd7, 32'hA5A5A5A5); rd(5'd7, 5'd3);
    exp_now(c_rd0, 32'hA5A5A5A5); exp_now(c_bsy0, 32'h0);
    exp_now(c_nb_rd0, 32'h0); exp_now(c_rd1, 32'h12345678);
    step();
    idle(); rd(5'd7, 5'd7);
    exp_now(c_nb_rd0, 32'hA5A5A5A5); exp_now(c_rd1, 32'hA5A5A5A5);
    step();

    // Write conflict: highest port wins for bypass and storage.
    wr(0, 5'd9, 32'h1111); wr(1, 5'd9, 32'h2222); rd(5'd9, 5'd9);
    exp_now(c_rd0, 32'h2222); exp_now(c_rd1, 32'h2222);
    exp_now(c_nb_rd0, 32'h0);
    step();
    idle(); rd(5'd9, 5'd9);
    exp_now(c_rd0, 32'h2222); exp_now(c_nb_rd0, 32'h2222);
    step();

    // Scoreboard: reserve r4; a same-cycle reserve is not yet visible.
    rsv(5'd4); rd(5'd4, 5'd4);
    exp_now(c_bsy0, 32'h0);
    exp_post(c_cnt, 32'h1); exp_post(c_nb_cnt, 32'h1);
    step();
    idle(); rd(5'd4, 5'd4);
    exp_now(c_bsy0, 32'h1); exp_now(c_nb_bs0, 32'h1);
    step();
    // Reserve and write together: reserve wins, data still lands.
    rsv(5'd4); wr(0, 5'd4, 32'h55); rd(5'd4, 5'd4);
    exp_now(c_rd1, 32'h55); exp_now(c_bsy1, 32'h0); exp_now(c_nb_bs0, 32'h1);
    exp_post(c_cnt, 32'h1);
    step();
    idle(); rd(5'd4, 5'd4);
    exp_now(c_rd0, 32'h55); exp_now(c_bsy0, 32'h1);
    step();
    wr(1, 5'd4, 32'h66); rd(5'd4, 5'd4);
    exp_post(c_cnt, 32'h0);
    step();
    idle(); rd(5'd4, 5'd4);
    exp_now(c_rd0, 32'h66); exp_now(c_bsy0, 32'h0); exp_now(c_nb_bs0, 32'h0);
    step();

    // Two busy registers cleared by two ports in one cycle.
    rsv(5'd10); exp_post(c_cnt, 32'h1); step();
    idle(); rsv(5'd11); exp_post(c_cnt, 32'h2); step();
    idle(); wr(0, 5'd10, 32'hA); wr(1, 5'd11, 32'hB);
    exp_post(c_cnt, 32'h0); exp_post(c_nb_cnt, 32'h0);
    step();

    // Zero register ignores writes and reservations, even under bypass.
    rsv(5'd13); exp_post(c_cnt, 32'h1); step();
    idle(); wr(0, 5'd0, 32'hFFFFFFFF); wr(1, 5'd0, 32'hFFFFFFFF);
    rsv(5'd0); rd(5'd0, 5'd0);
    exp_now(c_rd0, 32'h0); exp_now(c_bsy0, 32'h0); exp_now(c_rd1, 32'h0);
    exp_post(c_cnt, 32'h1);
    step();
    idle(); rd(5'd0, 5'd13);
    exp_now(c_rd0, 32'h0); exp_now(c_bsy0, 32'h0); exp_now(c_nb_rd0, 32'h0);
    exp_now(c_bsy1, 32'h1);
    step();

    // Reset mid-operation discards that cycle's traffic.
    rst = 1'b1; rsv(5'd12); wr(0, 5'd3, 32'hCAFE); rd(5'd3, 5'd13);
    exp_now(c_rd0, 32'h0); exp_now(c_bsy1, 32'h0);
    exp_post(c_cnt, 32'h0);
    step();
    rst = 1'b0; idle(); wr(0, 5'd2, 32'hBEEF); rd(5'd3, 5'd12);
    exp_now(c_rd0, 32'h0); exp_now(c_bsy1, 32'h0); exp_now(c_nb_rd0, 32'h0);
    step();
    idle(); rd(5'd2, 5'd13);
    exp_now(c_rd0, 32'hBEEF); exp_now(c_nb_rd0, 32'hBEEF); exp_now(c_bsy1, 32'h0);
    exp_now(c_cnt, 32'h0);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file with an integrated busy scoreboard. Successor to the 2-read/1-write architectural register file.
- Sits between decode (reads, destination reservation) and writeback (multiple write ports).
- Provides same-cycle write-to-read bypass so decode never stalls on a writeback landing in the current cycle.
- All state updates occur on the rising edge; no negedge writes.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 32, number of registers; must be a power of two and at least 2.
- NREAD, 2, number of read ports.
- NWRITE, 2, number of write ports.
- ZERO_REG, 1, when 1, register 0 always reads 0, ignores writes, and is never busy.
- BYPASS, 1, when 1, same-cycle write data is forwarded to read ports.
- Derived localparam AW = $clog2(DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  NWRITE  per-port write enable.
- wr_addr  in  NWRITE*AW  packed write addresses; port k is bits [k*AW +: AW].
- wr_data  in  NWRITE*WIDTH  packed write data.
- rsv_en  in  1  reserve (mark busy) a destination register.
- rsv_addr  in  AW  register to reserve.
- rd_addr  in  NREAD*AW  packed read addresses.
- rd_data  out  NREAD*WIDTH  packed read data, combinational.
- rd_busy  out  NREAD  per-port 1 = the value read is not yet produced.
- busy_cnt  out  AW+1  registered count of busy registers.

Behaviour:
- Reset: on a rising edge with rst=1, all registers become 0, all busy bits clear, and busy_cnt becomes 0. Wr/rsv inputs are ignored that cycle.
- While rst=1, rd_data is 0 and rd_busy is 0 for all read ports, regardless of state.
- Write: on a rising edge, for each k with wr_en[k]=1, reg[wr_addr[k]] <= wr_data[k]. The write also clears busy[wr_addr[k]].
- Write conflict: when two or more enabled ports target the same address, the highest-index port wins, for both the stored data and the bypass value.
- Zero register: when ZERO_REG=1, writes and reservations to address 0 are dropped. Reads of address 0 return 0 with rd_busy=0, including under bypass.
- Reserve: on a rising edge with rsv_en=1, busy[rsv_addr] <= 1.
- Reserve and write to the same address in the same cycle: the reserve wins, so busy stays or becomes 1 and the data is still written. This models a new producer issued while the old producer retires.
- Read, combinational, with zero added latency.
- With BYPASS=1: if any enabled write targets rd_addr[j] this cycle, rd_data[j] = the winning wr_data and rd_busy[j] = 0. Otherwise rd_data[j] = reg[rd_addr[j]] and rd_busy[j] = busy[rd_addr[j]].
- A same-cycle rsv_en does not affect reads until the next cycle.
- With BYPASS=0: reads return stored state only, and a write becomes visible the cycle after.
- busy_cnt: registered, equal to the popcount of the busy vector after the edge. It is recomputed from the next-state busy vector, not incrementally, so multi-port clears cannot underflow. Range is 0..DEPTH.
- Any number of read ports may read the same address; no read-port conflicts exist.
- Reset mid-operation: pending writes and reservations in the reset cycle are discarded. The first post-reset edge behaves normally.
- Out-of-range addresses are impossible by construction (AW bits, DEPTH a power of two).

Decomposition:
- Shared package, extending define.v: `WORD_WIDTH, `REG_NUM, and `REG_NUM_LOG as parameter defaults.
- New constant `RF_ZERO_REG.
- One natural sub-module: regfile_wr_arbiter. Given one address, it scans the NWRITE ports in ascending order and returns hit + winning data.
- regfile_wr_arbiter is instantiated once per read port (bypass) and once per register (storage update) via generate.

Test Plan:
- Reset: drive writes of 0xDEADBEEF to r5 during rst=1, then deassert. Require rd(r5)=0, rd_busy=0, and busy_cnt=0.
- Basic write/read: write r3=0x12345678 on port 0, then read r3 on both ports the next cycle. Require 0x12345678 on both ports with rd_busy=0.
- Bypass: write r7=0xA5A5A5A5 while reading r7 in the same cycle. Require rd_data=0xA5A5A5A5 combinationally when BYPASS=1, and the old value 0 when BYPASS=0.
- Write conflict: port0 writes r9=0x1111 and port1 writes r9=0x2222 in the same cycle. Require the bypassed and stored value to be 0x2222.
- Scoreboard: reserve r4 → the next cycle rd_busy=1 and busy_cnt=1. Then reserve r4 and write r4=0x55 simultaneously → busy stays 1 and data reads 0x55. Then write r4 alone → busy=0 and busy_cnt=0.
- Zero register: write r0=0xFFFFFFFF and reserve r0. Require rd(r0)=0, rd_busy=0, and busy_cnt unchanged.
